// File: rtl/rand_pkg.sv
// ============================================================================
// Package : rand_pkg
// Purpose : Shared types and constants for the bounded random-draw engine.
//           - FSM state encoding for rand_range_gen
//           - default LFSR feedback masks for 16/32/64-bit states
//           - default reset/substitute seed
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } rng_state_e;

  // Feedback masks: bit i set means state[i] participates in the feedback XOR.
  localparam logic [15:0] TAPS16 = 16'hB400;                // taps 15,13,12,10
  localparam logic [31:0] TAPS32 = 32'h8020_0003;           // taps 31,21,1,0
  localparam logic [63:0] TAPS64 = 64'hD800_0000_0000_0000; // taps 63,62,60,59

  localparam logic [31:0] SEED_RST_DEFAULT = 32'h1ACE_B00C;

endpackage

`default_nettype wire

// File: rtl/lfsr_core.sv
// ============================================================================
// Module  : lfsr_core
// Purpose : Free-running shift-left LFSR with reseed and lockup guard.
//           The state never stalls; a load takes priority over advancing.
// Ports   : clk   - clock
//           rst   - asynchronous active-low reset
//           load  - reseed strobe
//           seed  - reseed value (zero is replaced by SEED_RST)
//           state - current LFSR state
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_core
  import rand_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(TAPS32),
  parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(SEED_RST_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  logic             w_fb;

  assign w_fb = ^(r_state & TAPS);

  // A zero seed or a zero state (only reachable with a degenerate TAPS)
  // would lock the register; both are replaced by SEED_RST.
  always_comb begin
    w_next = {r_state[WIDTH-2:0], w_fb};
    if (load) begin
      w_next = (seed == '0) ? SEED_RST : seed;
    end else if (r_state == '0) begin
      w_next = SEED_RST;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEED_RST;
    end else begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: rtl/rand_range_gen.sv
// ============================================================================
// Module  : rand_range_gen
// Purpose : LFSR random source with a rejection-sampling draw engine that
//           returns integers in [0, limit) over a valid/ready handshake.
// Ports   : clk, rst (async active-low)
//           load, seed              - reseed the LFSR
//           req_valid/req_ready     - draw request, req_limit = exclusive bound
//           rsp_valid/rsp_ready     - result, rsp_data / rsp_biased
//           rand_raw                - current LFSR state
//           retry_cnt               - rejected-candidate counter
// Option  : RAND_STATS_EN - when defined, retry_cnt counts rejected
//           candidates (saturating); otherwise it is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rand_range_gen
  import rand_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS32),
  parameter logic [WIDTH-1:0] SEED_RST  = WIDTH'(SEED_RST_DEFAULT),
  parameter int               OUT_W     = 8,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_biased,
  output logic [WIDTH-1:0] rand_raw,
  output logic [15:0]      retry_cnt
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [WIDTH-1:0] w_state;

  lfsr_core #(
    .WIDTH    (WIDTH),
    .TAPS     (TAPS),
    .SEED_RST (SEED_RST)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .seed  (seed),
    .state (w_state)
  );

  assign rand_raw = w_state;

  rng_state_e       r_st, w_st_nxt;
  logic [OUT_W-1:0] r_limit, w_limit_nxt;
  logic [TRY_W-1:0] r_tries, w_tries_nxt;
  logic [OUT_W-1:0] r_rsp_data, w_data_nxt;
  logic             r_rsp_biased, w_biased_nxt;

  logic [OUT_W-1:0] w_mask;
  logic [OUT_W-1:0] w_cand;
  logic             w_hit;
  logic             w_last;

  // Smear the highest set bit of (limit-1) downwards to get 2^k-1 >= limit-1.
  always_comb begin
    w_mask = r_limit - OUT_W'(1);
    for (int i = 1; i < OUT_W; i = i * 2) begin
      w_mask = w_mask | (w_mask >> i);
    end
  end

  assign w_cand = w_state[OUT_W-1:0] & w_mask;
  assign w_hit  = (w_cand < r_limit);
  assign w_last = (r_tries == TRY_W'(MAX_TRIES - 1));

  always_comb begin
    w_st_nxt     = r_st;
    w_limit_nxt  = r_limit;
    w_tries_nxt  = r_tries;
    w_data_nxt   = r_rsp_data;
    w_biased_nxt = r_rsp_biased;
    case (r_st)
      ST_IDLE: begin
        if (req_valid) begin
          w_limit_nxt = req_limit;
          w_tries_nxt = '0;
          if (req_limit == '0) begin
            w_data_nxt   = '0;
            w_biased_nxt = 1'b1;
            w_st_nxt     = ST_DONE;
          end else begin
            w_st_nxt = ST_DRAW;
          end
        end
      end
      ST_DRAW: begin
        if (w_hit) begin
          w_data_nxt   = w_cand;
          w_biased_nxt = 1'b0;
          w_st_nxt     = ST_DONE;
        end else begin
          w_tries_nxt = r_tries + TRY_W'(1);
          if (w_last) begin
            // mask < 2*limit, so cand - limit is already in range
            w_data_nxt   = w_cand - r_limit;
            w_biased_nxt = 1'b1;
            w_st_nxt     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          w_st_nxt = ST_IDLE;
        end
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st         <= ST_IDLE;
      r_limit      <= '0;
      r_tries      <= '0;
      r_rsp_data   <= '0;
      r_rsp_biased <= 1'b0;
    end else begin
      r_st         <= w_st_nxt;
      r_limit      <= w_limit_nxt;
      r_tries      <= w_tries_nxt;
      r_rsp_data   <= w_data_nxt;
      r_rsp_biased <= w_biased_nxt;
    end
  end

  assign req_ready  = (r_st == ST_IDLE);
  assign rsp_valid  = (r_st == ST_DONE);
  assign rsp_data   = r_rsp_data;
  assign rsp_biased = r_rsp_biased;

`ifdef RAND_STATS_EN
  logic [15:0] r_retry;
  logic        w_reject;

  assign w_reject = (r_st == ST_DRAW) && !w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retry <= '0;
    end else if (w_reject && (r_retry != 16'hFFFF)) begin
      r_retry <= r_retry + 16'd1;
    end
  end

  assign retry_cnt = r_retry;
`else
  assign retry_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rand_range_gen.sv
`default_nettype none

module tb_rand_range_gen;

  localparam int          WIDTH     = 32;
  localparam int          OUT_W     = 8;
  localparam int          MAX_TRIES = 2;
  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [31:0] SEED      = 32'h1ACE_B00C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [31:0] seed = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_limit = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_data;
  logic        rsp_biased;
  logic [31:0] rand_raw;
  logic [15:0] retry_cnt;

  always #5 clk = ~clk;

  rand_range_gen #(
    .WIDTH     (WIDTH),
    .TAPS      (TAPS),
    .SEED_RST  (SEED),
    .OUT_W     (OUT_W),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .seed       (seed),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_limit  (req_limit),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_biased (rsp_biased),
    .rand_raw   (rand_raw),
    .retry_cnt  (retry_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference LFSR model ----------------
  function automatic logic [31:0] step(input logic [31:0] s);
    if (s == '0) return SEED;
    return {s[30:0], ^(s & TAPS)};
  endfunction

  logic [31:0] m_state;
  always @(posedge clk or negedge rst) begin
    if (!rst)       m_state <= SEED;
    else if (load)  m_state <= (seed == '0) ? SEED : seed;
    else            m_state <= step(m_state);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] data;
    logic       biased;
    int         t_req;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  int   exp_rej = 0;

  function automatic exp_t predict(input logic [7:0] lim, input int t, input logic [31:0] s0);
    exp_t e;
    logic [31:0] s;
    logic [7:0]  mask, lm1, cand;
    e.t_req = t; e.data = '0; e.biased = 1'b1; e.lat = 1;
    if (lim != 8'd0) begin
      s = s0;
      lm1 = lim - 8'd1;
      mask = 8'd0;
      while (mask < lm1) mask = {mask[6:0], 1'b1};
      for (int i = 0; i < MAX_TRIES; i++) begin
        cand = s[7:0] & mask;
        if (cand < lim) begin
          e.data = cand; e.biased = 1'b0; e.lat = i + 2;
          break;
        end
        exp_rej++;
        if (i == MAX_TRIES - 1) begin
          e.data = cand - lim; e.biased = 1'b1; e.lat = i + 2;
        end
        s = step(s);
      end
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic do_req(input logic [7:0] lim);
    int t;
    int guard = 0;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout actual=0 required=1");
    end else begin
      req_valid = 1'b1;
      req_limit = lim;
      t = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
      sbq.push_back(predict(lim, t, m_state));
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((sbq.size() != 0 || !req_ready) && g < 50) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
    end
  endtask

  // ---------------- monitor ----------------
  logic        in_rsp = 1'b0;
  exp_t        cur;
  logic        track16 = 1'b0;
  logic [15:0] seen16 = '0;
  logic        zero_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      check("rand_raw", rand_raw, m_state);
      if (rand_raw == '0) zero_seen = 1'b1;
      if (rsp_valid && !in_rsp) begin
        in_rsp = 1'b1;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp actual=%0h required=none", rsp_data);
        end else begin
          cur = sbq.pop_front();
          check("rsp_data", rsp_data, cur.data);
          check("rsp_biased", rsp_biased, cur.biased);
          check("latency", cyc - cur.t_req, cur.lat);
          if (rsp_data >= 8'd16) track16 = track16; // keeps only in-range values
          else if (track16) seen16[rsp_data[3:0]] = 1'b1;
        end
      end else if (rsp_valid && in_rsp) begin
        check("rsp_hold", {rsp_biased, rsp_data}, {cur.biased, cur.data});
      end else if (!rsp_valid) begin
        in_rsp = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] seq_tab [8] = '{32'd1, 32'd3, 32'd6, 32'd13, 32'd27, 32'd54, 32'd109, 32'd219};
  logic [7:0]  lim_tab [16] = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd10, 8'd1, 8'd0, 8'd255,
                                8'd128, 8'd3, 8'd200, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_biased", rsp_biased, 1'b0);
    check("rst_rand_raw", rand_raw, SEED);
    check("rst_retry_cnt", retry_cnt, 16'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // reseed with 1, then shift sequence
    load = 1'b1; seed = 32'h1;
    @(posedge clk); #1;
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("seq", rand_raw, seq_tab[i]);
      @(posedge clk); #1;
    end

    // zero seed is substituted
    load = 1'b1; seed = 32'h0;
    @(posedge clk); #1;
    load = 1'b0;
    check("zero_seed", rand_raw, SEED);

    // hand-computed boundaries: limit 0 and limit 1
    do_req(8'd0);
    drain();
    do_req(8'd1);
    drain();

    // directed limits
    for (int i = 0; i < 16; i++) do_req(lim_tab[i]);
    drain();

    // power-of-two limit: never rejects, latency 2, all values appear
    track16 = 1'b1; seen16 = '0;
    for (int i = 0; i < 1000; i++) do_req(8'd16);
    drain();
    track16 = 1'b0;
    check("all16_seen", seen16, 16'hFFFF);

    // rejection-heavy limit
    for (int i = 0; i < 200; i++) do_req(8'd9);
    drain();

    // backpressure: response held, no new request accepted
    rsp_ready = 1'b0;
    do_req(8'd9);
    for (int i = 0; i < 20; i++) begin
      check("bp_req_ready", req_ready, 1'b0);
      @(posedge clk); #1;
    end
    check("bp_rsp_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    drain();

`ifdef RAND_STATS_EN
    check("retry_cnt", retry_cnt, exp_rej);
`else
    check("retry_cnt", retry_cnt, 16'h0);
`endif

    // async reset in the middle of a draw
    do_req(8'd16);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_rsp_data", rsp_data, 8'h00);
    check("mid_rst_rsp_biased", rsp_biased, 1'b0);
    check("mid_rst_rand_raw", rand_raw, SEED);
    check("mid_rst_retry_cnt", retry_cnt, 16'h0);
    sbq.delete();
    exp_rej = 0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    do_req(8'd0);
    drain();

    check("no_zero_state", zero_seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
